// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte FIFO feeding an 8N1/8E1/8O1 serial transmitter.
// tx is a registered copy of the FSM output, so it lags the state by one clock.
module uart_byte_tx #(
   parameter int CLK_DIV    = 5208,
   parameter int FIFO_DEPTH = 4,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [7:0]    head;
   logic [7:0]    shreg;
   logic [7:0]    shreg_nx;
   logic          par;
   logic          par_nx;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_cnt_nx;
   logic [BW-1:0] baud;
   logic [BW-1:0] baud_nx;
   logic          tx_nx;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;
   logic          wrap;

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign din_ready  = !full;
   assign push       = din_valid && din_ready;
   assign fifo_count = wr_ptr - rd_ptr;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign wrap       = (baud == BAUD_MAX);
   assign busy       = (state != IDLE) || !empty;

   // FIFO storage: written on accepted pushes only
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   // FIFO pointers: extra MSB separates full from empty
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // FSM and datapath registers, tx included
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         par     <= 1'b0;
         bit_cnt <= '0;
         baud    <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         par     <= par_nx;
         bit_cnt <= bit_cnt_nx;
         baud    <= baud_nx;
         tx      <= tx_nx;
      end
   end

   // Next state, line level, and pop/load of the next byte
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      par_nx     = par;
      bit_cnt_nx = bit_cnt;
      baud_nx    = wrap ? '0 : baud + 1'b1;
      pop        = 1'b0;
      tx_nx      = 1'b1;
      unique case (state)
         IDLE: begin
            baud_nx = '0;
            if (!empty) begin
               pop        = 1'b1;
               shreg_nx   = head;
               par_nx     = (^head) ^ PARITY_ODD;
               bit_cnt_nx = '0;
               state_nx   = START;
            end
         end
         START: begin
            tx_nx = 1'b0;
            if (wrap) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            tx_nx = shreg[0];
            if (wrap) begin
               shreg_nx   = {1'b0, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_nx = PARITY_EN ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            tx_nx = par;
            if (wrap) begin
               state_nx = STOP;
            end
         end
         STOP: begin
            tx_nx = 1'b1;
            if (wrap) begin
               if (!empty) begin
                  pop        = 1'b1;
                  shreg_nx   = head;
                  par_nx     = (^head) ^ PARITY_ODD;
                  bit_cnt_nx = '0;
                  state_nx   = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: four transmitter configurations against a frame-timeline model.
// The model places each accepted byte at max(accept+2, line free) and derives all outputs.
module tb_uart_byte_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] rst;
   logic [3:0] vld;
   logic [3:0] rdy;
   logic [3:0] txw;
   logic [3:0] bsy;
   logic [7:0] din [4];
   logic [2:0] cnt [4];

   uart_byte_tx #(.CLK_DIV(5208), .FIFO_DEPTH(4),
                  .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_slow (
      .clk(clk), .reset(rst[0]), .din(din[0]), .din_valid(vld[0]),
      .din_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .fifo_count(cnt[0]));

   uart_byte_tx #(.CLK_DIV(8), .FIFO_DEPTH(4),
                  .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_fast (
      .clk(clk), .reset(rst[1]), .din(din[1]), .din_valid(vld[1]),
      .din_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .fifo_count(cnt[1]));

   uart_byte_tx #(.CLK_DIV(8), .FIFO_DEPTH(4),
                  .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
      .clk(clk), .reset(rst[2]), .din(din[2]), .din_valid(vld[2]),
      .din_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]), .fifo_count(cnt[2]));

   uart_byte_tx #(.CLK_DIV(8), .FIFO_DEPTH(4),
                  .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
      .clk(clk), .reset(rst[3]), .din(din[3]), .din_valid(vld[3]),
      .din_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

   typedef struct {
      int         inst;
      int         a;
      int         s;
      logic [7:0] b;
   } fr_t;

   fr_t        q[$];
   int         t_free [4];
   int         first_fall [4];
   logic [3:0] tx_prev;
   int         checks;
   int         errors;
   int         t;

   function automatic int dv(input int i);
      return (i == 0) ? 5208 : 8;
   endfunction

   function automatic bit pen(input int i);
      return (i >= 2);
   endfunction

   function automatic bit odd(input int i);
      return (i == 3);
   endfunction

   function automatic int flen(input int i);
      return (pen(i) ? 11 : 10) * dv(i);
   endfunction

   function automatic int e_cnt(input int i, input int tt);
      int n = 0;
      foreach (q[j]) begin
         if (q[j].inst == i) begin
            if (q[j].a <= tt) n++;
            if (q[j].s - 1 <= tt) n--;
         end
      end
      return n;
   endfunction

   function automatic logic e_tx(input int i, input int tt);
      logic [7:0] bb;
      int k;
      foreach (q[j]) begin
         if (q[j].inst == i && q[j].s <= tt && tt < q[j].s + flen(i)) begin
            bb = q[j].b;
            k = (tt - q[j].s) / dv(i);
            if (k == 0) return 1'b0;
            if (k <= 8) return bb[k-1];
            if (k == 9 && pen(i)) return (^bb) ^ odd(i);
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   function automatic logic e_busy(input int i, input int tt);
      if (e_cnt(i, tt) > 0) return 1'b1;
      foreach (q[j]) begin
         if (q[j].inst == i && q[j].s - 1 <= tt &&
             tt < q[j].s - 1 + flen(i)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic summary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
         if (errors >= 200) begin
            summary();
            $finish;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("tx%0d", i), 32'(txw[i]), 32'(e_tx(i, t)));
         chk($sformatf("cnt%0d", i), 32'(cnt[i]), 32'(e_cnt(i, t)));
         chk($sformatf("rdy%0d", i), 32'(rdy[i]), 32'(e_cnt(i, t) < 4));
         chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(e_busy(i, t)));
         if (tx_prev[i] && !txw[i] && first_fall[i] < 0) first_fall[i] = t;
         tx_prev[i] = txw[i];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      t = cyc;
      check_all();
      for (int j = q.size() - 1; j >= 0; j--) begin
         if (q[j].s + flen(q[j].inst) < t) q.delete(j);
      end
      for (int i = 0; i < 4; i++) begin
         if (!vld[i]) din[i] = 8'($urandom);
      end
   endtask

   task automatic tick_until(input int tt);
      while (t < tt) tick();
   endtask

   task automatic model_accept(input int i, input int a, input logic [7:0] b);
      fr_t e;
      e.inst = i;
      e.a = a;
      e.s = (a + 2 > t_free[i]) ? a + 2 : t_free[i];
      e.b = b;
      q.push_back(e);
      t_free[i] = e.s + flen(i);
   endtask

   task automatic model_clear(input int i);
      for (int j = q.size() - 1; j >= 0; j--) begin
         if (q[j].inst == i) q.delete(j);
      end
      t_free[i] = 0;
   endtask

   task automatic push(input int i, input logic [7:0] b);
      int n = 0;
      while (e_cnt(i, t) >= 4) begin
         tick();
         n++;
         if (n > 5000) begin
            chk("push_wait", 0, 1);
            return;
         end
      end
      din[i] = b;
      vld[i] = 1'b1;
      model_accept(i, t + 1, b);
      tick();
      vld[i] = 1'b0;
   endtask

   task automatic get_fall(input int i, input int k, output int ff);
      int n = 0;
      while (first_fall[i] < 0 && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("fall_lat%0d", i), first_fall[i] - k, 2);
      ff = (first_fall[i] < 0) ? k + 2 : first_fall[i];
   endtask

   task automatic wait_idle(input int i);
      tick_until(t_free[i] + 2);
   endtask

   int         ff;
   int         ff2;
   int         ff3;
   int         k;
   int         p;
   int         bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'h81, 8'h3C, 8'hC3};

   initial begin
      rst = '1;
      vld = '0;
      tx_prev = '1;
      checks = 0;
      errors = 0;
      t = 0;
      for (int i = 0; i < 4; i++) begin
         din[i] = 8'h00;
         t_free[i] = 0;
         first_fall[i] = -1;
      end
      @(posedge clk);
      repeat (5) tick();
      rst = '0;
      repeat (20000) tick();

      first_fall[0] = -1;
      push(0, 8'hA5);
      k = t;
      get_fall(0, k, ff);
      for (int j = 0; j < 10; j++) begin
         tick_until(ff + j * 5208 + 2604);
         chk($sformatf("a5_bit%0d", j), 32'(txw[0]), 32'(bits[j]));
         if (j == 5) chk("a5_busy", 32'(bsy[0]), 1);
      end
      tick_until(ff + 52079);
      chk("a5_stop", 32'(txw[0]), 1);
      tick_until(ff + 52080);
      chk("a5_end_tx", 32'(txw[0]), 1);
      chk("a5_end_busy", 32'(bsy[0]), 0);

      for (int j = 0; j < 6; j++) begin
         push(1, burst[j]);
         if (j == 4) begin
            chk("burst_full_rdy", 32'(rdy[1]), 0);
            chk("burst_full_cnt", 32'(cnt[1]), 4);
         end
      end
      wait_idle(1);

      first_fall[2] = -1;
      first_fall[3] = -1;
      push(2, 8'h07);
      k = t;
      push(3, 8'h07);
      push(2, 8'h03);
      push(3, 8'h03);
      get_fall(2, k, ff2);
      ff3 = (first_fall[3] < 0) ? k + 3 : first_fall[3];
      chk("fall_lat3", ff3 - k, 3);
      for (int n = 0; n < 200; n++) begin
         tick();
         for (int i = 2; i < 4; i++) begin
            p = (i == 2) ? ff2 : ff3;
            if (t == p + 76)
               chk($sformatf("par07_%0d", i), 32'(txw[i]), 32'(i == 2));
            if (t == p + 87)
               chk($sformatf("stop_%0d", i), 32'(txw[i]), 1);
            if (t == p + 88)
               chk($sformatf("frame88_%0d", i), 32'(txw[i]), 0);
            if (t == p + 88 + 76)
               chk($sformatf("par03_%0d", i), 32'(txw[i]), 32'(i == 3));
         end
      end
      wait_idle(2);
      wait_idle(3);

      first_fall[1] = -1;
      push(1, 8'h96);
      k = t;
      push(1, 8'h11);
      push(1, 8'h22);
      chk("mid_cnt", 32'(cnt[1]), 2);
      get_fall(1, k, ff);
      tick_until(ff + 4 * 8 + 3);
      rst[1] = 1'b1;
      model_clear(1);
      tick();
      chk("rst_tx", 32'(txw[1]), 1);
      chk("rst_cnt", 32'(cnt[1]), 0);
      rst[1] = 1'b0;
      tick();
      first_fall[1] = -1;
      push(1, 8'h5A);
      k = t;
      get_fall(1, k, ff);
      tick_until(ff + 8 * 8 + 4);
      chk("5a_d7", 32'(txw[1]), 0);
      wait_idle(1);

      first_fall[1] = -1;
      push(1, 8'h12);
      k = t;
      push(1, 8'h34);
      push(1, 8'h56);
      get_fall(1, k, ff);
      p = ff + 80 - 1;
      tick_until(p - 1);
      chk("sim_pre_cnt", 32'(cnt[1]), 2);
      push(1, 8'h78);
      chk("sim_cnt", 32'(cnt[1]), 2);
      wait_idle(1);

      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 30)) tick();
         push(1, 8'($urandom));
         if ($urandom_range(0, 2) == 0)
            push(2 + int'($urandom_range(0, 1)), 8'($urandom));
      end
      wait_idle(1);
      wait_idle(2);
      wait_idle(3);
      repeat (4) tick();

      summary();
      $finish;
   end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial UART transmitter that converts parallel bytes into 8N1 (optionally 8E1/8O1) frames on a single `tx` line. It is the transmit counterpart of the `rx` serial input consumed by the DA path. It replaces file-driven stimulus with a synthesizable source for board loopback and for streaming sample bytes to a host. A small FIFO decouples the byte producer from the slow line rate.

## Interface
- `CLK_DIV`, 5208: clk cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, 2..16.
- `PARITY_EN`, 0: 1 inserts a parity bit between D7 and the stop bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.

- `clk`  in  1  system clock; every register is clocked on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `din`  in  8  byte to send.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  FIFO can accept a byte; equals !full.
- `tx`  out  1  serial line; idles at 1.
- `busy`  out  1  1 whenever a frame is in progress or the FIFO is non-empty.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.

## Operation
- Push: a byte is written when `din_valid` && `din_ready` at a clock edge. `din_ready` is derived from the registered count, so no byte is ever dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit and baud counters, set `tx`=0, and go to START.
  - START: hold `tx`=0 for CLK_DIV cycles, then go to DATA with `tx`=D0.
  - DATA: shift LSB first. Each bit is held CLK_DIV cycles. The 3-bit bit counter runs 0..7. After D7, go to PARITY if `PARITY_EN`, otherwise to STOP.
  - PARITY: `tx` = XOR(D7..D0) XOR `PARITY_ODD`, held CLK_DIV cycles.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop the next byte and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: width clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps, and a state/bit advances at the wrap.
- FIFO: circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguishable.
  - A simultaneous push and pop in the same cycle leaves `fifo_count` unchanged.
  - A push when full is impossible because `din_ready`=0.
  - A pop when empty never occurs, because the FSM checks for non-empty first.
- `tx` is driven directly from a register, so it is glitch-free.

## Timing
- Reset values: `tx`=1, `din_ready`=1, `busy`=0, `fifo_count`=0, FSM=IDLE, both pointers=0, counters=0.
- Latency: a byte accepted at edge k into an empty FIFO while in IDLE produces a `tx` falling edge at edge k+2. The pop happens at k+1 and `tx` is registered at k+2.
- Frame length: 10*CLK_DIV cycles, or 11*CLK_DIV with parity. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `busy` rises the edge after the first push and falls on the edge at which STOP completes with the FIFO empty.
- Reset asserted mid-frame: at the next edge the frame is aborted, `tx`=1, and the FIFO is flushed. The partial frame is not completed.
- `din` and `din_valid` are sampled only at the edge where `din_ready`=1. `din` may change freely when it is not accepted.

## Test plan
- **Reset idle.** Hold `reset`=1 for 5 cycles, then release. Require `tx`=1, `busy`=0, `din_ready`=1, and `fifo_count`=0 throughout, with no activity over 20000 cycles.
- **Single byte 0xA5 (CLK_DIV=5208).** Require the `tx` fall 2 cycles after accept. Sampling at bit centers must give 0, 1,0,1,0,0,1,0,1, 1. Frame end must fall at 52080 cycles, after which `busy`=0.
- **Burst with FIFO_DEPTH=4, CLK_DIV=8.** Push 0x00, 0xFF, 0x55, 0x81, 0x3C, 0xC3 on consecutive cycles.
  - `din_ready` must drop after the 5th accepted byte (1 shifting plus 4 queued).
  - All accepted bytes must appear in order with no gap between frames.
  - Byte 6 must be accepted once space frees.
- **Parity, PARITY_EN=1, CLK_DIV=8.**
  - With `PARITY_ODD`=0, byte 0x07 gives parity bit 1 and byte 0x03 gives 0.
  - With `PARITY_ODD`=1 the values invert.
  - Frame is 88 cycles.
- **Reset mid-frame.** Assert `reset` during D3 of a frame with 2 bytes queued. Require `tx`=1 and `fifo_count`=0 the next cycle. A new byte 0x5A afterwards must transmit correctly.
- **Simultaneous push/pop.** With `fifo_count`=2, push on the same edge STOP pops. Require `fifo_count` stays 2 and the data order is preserved.
